// File: rtl/square_wave_gen.sv
// Purpose : programmable 50 % duty square-wave tone generator; freq in Hz, 0 = silence (optional SQW_ROUND_EN: round-to-nearest period).
// Latency : new half-period loaded CNT_W+1 cycles after a start (<= CNT_W+2 from a stable freq); silence takes effect on the next edge.
// Backpressure: none; freq is sampled every cycle and the output is free-running.
module square_wave_gen #(
    parameter int CLK_FREQ = 12000000,
    parameter int FREQ_W   = 16,
    parameter int CNT_W    = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FREQ_W-1:0] freq,
    output logic              sq_wave
);

`ifdef SQW_ROUND_EN
    localparam int NUM_W = CNT_W + 1;
`else
    localparam int NUM_W = CNT_W;
`endif
    localparam int DIV_W  = FREQ_W + 1;
    localparam int ITER_W = $clog2(CNT_W);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t            state, state_nxt;
    logic [FREQ_W-1:0] tgt;
    logic [DIV_W-1:0]  divisor;
    logic [DIV_W-1:0]  rem;
    logic [CNT_W-1:0]  quo;        // remaining numerator bits shift out, quotient bits shift in
    logic [ITER_W-1:0] iter;
    logic [CNT_W-1:0]  half_reg;
    logic [CNT_W-1:0]  counter;

    logic              silence;
    logic              start;
    logic              last;
    logic [NUM_W-1:0]  numer;
    logic [DIV_W:0]    shifted;
    logic              ge;
    logic [DIV_W-1:0]  diff;
    logic [DIV_W-1:0]  rem_nxt;
    logic [CNT_W-1:0]  quo_nxt;

    assign silence = (freq == '0);
    assign start   = (state == S_IDLE) && !silence && (freq != tgt);
    assign last    = (state == S_BUSY) && (iter == ITER_W'(CNT_W - 1));

    // Dividend: clock rate, plus freq when rounding to nearest
    always_comb begin
        numer = NUM_W'(CLK_FREQ);
`ifdef SQW_ROUND_EN
        numer = NUM_W'(CLK_FREQ) + NUM_W'(freq);
`endif
    end

    // One restoring-divide step; rem < divisor always, so the modular diff is exact when ge
    always_comb begin
        shifted = {rem, quo[CNT_W-1]};
        ge      = (shifted >= {1'b0, divisor});
        diff    = shifted[DIV_W-1:0] - divisor;
        rem_nxt = ge ? diff : shifted[DIV_W-1:0];
        quo_nxt = {quo[CNT_W-2:0], ge};
    end

    // Divider FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state: a silence request abandons any division in flight
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_BUSY;
            S_BUSY:  if (silence || last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Divider datapath: load dividend/divisor on start, then one quotient bit per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt     <= '0;
            divisor <= '0;
            rem     <= '0;
            quo     <= '0;
            iter    <= '0;
        end else if (silence) begin
            tgt <= '0;
        end else if (start) begin
            tgt     <= freq;
            divisor <= {freq, 1'b0};
            iter    <= '0;
`ifdef SQW_ROUND_EN
            rem     <= DIV_W'(numer[CNT_W]);
            quo     <= numer[CNT_W-1:0];
`else
            rem     <= '0;
            quo     <= numer;
`endif
        end else if (state == S_BUSY) begin
            rem  <= rem_nxt;
            quo  <= quo_nxt;
            iter <= iter + ITER_W'(1);
        end
    end

    // Tone counter: reload restarts the count but keeps the level; zero period means silence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_reg <= '0;
            counter  <= '0;
            sq_wave  <= 1'b0;
        end else if (silence) begin
            half_reg <= '0;
            counter  <= '0;
            sq_wave  <= 1'b0;
        end else if (last) begin
            half_reg <= quo_nxt;
            counter  <= '0;
            if (quo_nxt == '0) sq_wave <= 1'b0;
        end else if (half_reg != '0) begin
            if (counter == half_reg - CNT_W'(1)) begin
                counter <= '0;
                sq_wave <= ~sq_wave;
            end else begin
                counter <= counter + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_square_wave_gen.sv
module tb_square_wave_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] freq = '0;
    logic        sq_wave;

    int n_vec = 0;
    int n_err = 0;

`ifdef SQW_ROUND_EN
    localparam int EXP_F7    = 857143;
    localparam int EXP_FFFF  = 92;
`else
    localparam int EXP_F7    = 857142;
    localparam int EXP_FFFF  = 91;
`endif

    always #5 clk = ~clk;

    square_wave_gen dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .freq   (freq),
        .sq_wave(sq_wave)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Negedges until sq_wave changes level; -1 if the budget runs out
    task automatic wait_toggle(input int budget, output int n);
        logic l0;
        l0 = sq_wave;
        n  = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (sq_wave !== l0) begin
                n = i;
                break;
            end
        end
    endtask

    // Negedges until the period register holds exp; -1 if the budget runs out
    task automatic wait_half(input logic [23:0] exp, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (dut.half_reg === exp) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int   n, p1, p2;
        logic lvl;

        // Reset state with 440 Hz already requested
        freq = 16'd440;
        repeat (3) @(negedge clk);
        check_val("rst_sq", {31'b0, sq_wave}, 32'd0);
        check_val("rst_half", {8'b0, dut.half_reg}, 32'd0);
        rst_n = 1'b1;
        wait_half(24'd13636, 40, n);
        check_val("s1_lat", n, 32'd25);
        wait_toggle(14000, n);
        check_val("s1_first", n, 32'd13636);
        check_val("s1_rise", {31'b0, sq_wave}, 32'd1);
        wait_toggle(14000, n);
        check_val("s1_phase", n, 32'd13636);

        // 440 -> 880 mid-phase: level kept, counter restarts at load
        repeat (1000) @(negedge clk);
        freq = 16'd880;
        lvl  = sq_wave;
        wait_half(24'd6818, 40, n);
        check_val("s2_lat", n, 32'd25);
        check_val("s2_keep", {31'b0, sq_wave}, {31'b0, lvl});
        wait_toggle(7000, n);
        check_val("s2_trans", n, 32'd6818);
        wait_toggle(7000, n);
        check_val("s2_phase", n, 32'd6818);

        // 1000 Hz: 6000-cycle phases, 12000-cycle period
        freq = 16'd1000;
        wait_half(24'd6000, 40, n);
        check_val("s3_lat", n, 32'd25);
        wait_toggle(6100, p1);
        check_val("s3_ph1", p1, 32'd6000);
        wait_toggle(6100, p2);
        check_val("s3_ph2", p2, 32'd6000);
        check_val("s3_period", p1 + p2, 32'd12000);

        // Silence while high, then resume at 440
        if (sq_wave == 1'b0) wait_toggle(7000, n);
        freq = 16'd0;
        @(negedge clk);
        check_val("s4_low", {31'b0, sq_wave}, 32'd0);
        check_val("s4_half0", {8'b0, dut.half_reg}, 32'd0);
        wait_toggle(6100, n);
        check_val("s4_quiet", n, 32'hFFFF_FFFF);
        freq = 16'd440;
        wait_half(24'd13636, 40, n);
        check_val("s4_resume", n, 32'd25);
        check_val("s4_stilllow", {31'b0, sq_wave}, 32'd0);

        // Two changes within 10 cycles: 880 result lands, then 1000
        freq = 16'd880;
        repeat (5) @(negedge clk);
        freq = 16'd1000;
        wait_half(24'd6818, 40, n);
        check_val("s5_880", n, 32'd20);
        wait_half(24'd6000, 40, n);
        check_val("s5_1000", n, 32'd25);
        wait_toggle(6100, n);
        check_val("s5_phase", n, 32'd6000);
        check_val("s5_level", {31'b0, sq_wave}, 32'd1);

        // Asynchronous reset between clock edges, then recovery
        repeat (1000) @(negedge clk);
        if (sq_wave == 1'b0) wait_toggle(7000, n);
        #3 rst_n = 1'b0;
        #1;
        check_val("s6_async_sq", {31'b0, sq_wave}, 32'd0);
        check_val("s6_async_half", {8'b0, dut.half_reg}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_half(24'd6000, 40, n);
        check_val("s6_lat", n, 32'd25);
        wait_toggle(6100, n);
        check_val("s6_first", n, 32'd6000);
        check_val("s6_rise", {31'b0, sq_wave}, 32'd1);

        // Boundary frequencies
        freq = 16'hFFFF;
        wait_half(24'(EXP_FFFF), 40, n);
        check_val("b_ffff_lat", n, 32'd25);
        wait_toggle(200, n);
        check_val("b_ffff_phase", n, EXP_FFFF);
        freq = 16'd7;
        wait_half(24'(EXP_F7), 40, n);
        check_val("b_f7", n, 32'd25);
        freq = 16'd1;
        wait_half(24'd6000000, 40, n);
        check_val("b_f1", n, 32'd25);
        freq = 16'd3;
        wait_half(24'd2000000, 40, n);
        check_val("b_f3", n, 32'd25);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
